// File: rtl/reg_access_ctrl.sv
// Register-file access sequencer: runs READ/WRITE/SWAP/ADD commands against an external
// two-read/one-write register file and returns the pre-command operand values.
module reg_access_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_a_i,
    input  logic [ADDR_W-1:0] cmd_addr_b_i,
    input  logic [ADDR_W-1:0] cmd_addr_d_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data1_o,
    output logic [DATA_W-1:0] rsp_data2_o,
    output logic              rsp_carry_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [ADDR_W-1:0] rf_raddr1_o,
    output logic [ADDR_W-1:0] rf_raddr2_o,
    input  logic [DATA_W-1:0] rf_rdata1_i,
    input  logic [DATA_W-1:0] rf_rdata2_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StExec,
        StWb2,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        OpRead  = 2'b00,
        OpWrite = 2'b01,
        OpSwap  = 2'b10,
        OpAdd   = 2'b11
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [ADDR_W-1:0]   addr_a_q, addr_b_q, addr_d_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   data1_q, data2_q;
    logic                carry_q;
    logic [DATA_W:0]     sum;
    logic                accept;
    logic                reading;

    assign sum     = {1'b0, rf_rdata1_i} + {1'b0, rf_rdata2_i};
    assign accept  = (state_q == StIdle) && cmd_valid_i;
    assign reading = (state_q == StRd) || (state_q == StExec) || (state_q == StWb2);

    // Ready is gated by rst_ni so it drops the instant reset asserts.
    assign cmd_ready_o = (state_q == StIdle) && rst_ni;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_data1_o = data1_q;
    assign rsp_data2_o = data2_q;
    assign rsp_carry_o = carry_q;
    assign rf_raddr1_o = reading ? addr_a_q : '0;
    assign rf_raddr2_o = reading ? addr_b_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_q     <= OpRead;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_d_q <= '0;
            wdata_q  <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= op_e'(cmd_op_i);
                addr_a_q <= cmd_addr_a_i;
                addr_b_q <= cmd_addr_b_i;
                addr_d_q <= cmd_addr_d_i;
                wdata_q  <= cmd_wdata_i;
            end
            // Operands are captured before any write lands, so responses hold pre-command values.
            if (state_q == StExec) begin
                data1_q <= rf_rdata1_i;
                data2_q <= rf_rdata2_i;
                carry_q <= (op_q == OpAdd) ? sum[DATA_W] : 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                state_d = StExec;
            end
            StExec: begin
                state_d = StResp;
                unique case (op_q)
                    OpRead: begin
                    end
                    OpWrite: begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = addr_a_q;
                        rf_wdata_o = wdata_q;
                    end
                    OpAdd: begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = addr_d_q;
                        rf_wdata_o = sum[DATA_W-1:0];
                    end
                    OpSwap: begin
                        rf_we_o    = 1'b1;
                        rf_waddr_o = addr_a_q;
                        rf_wdata_o = rf_rdata2_i;
                        state_d    = StWb2;
                    end
                    default: begin
                    end
                endcase
            end
            // Second half of SWAP: the original reg[A] comes from the EXEC capture.
            StWb2: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = addr_b_q;
                rf_wdata_o = data1_q;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural 16x16 register file attached.
module tb_reg_access_ctrl;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;
    localparam logic [1:0] OP_AD = 2'b11;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_carry, rf_we;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr_a, cmd_addr_b, cmd_addr_d, rf_waddr, rf_raddr1, rf_raddr2;
    logic [15:0] cmd_wdata, rsp_data1, rsp_data2, rf_wdata, rf_rdata1, rf_rdata2;
    logic [15:0] rf [16] = '{default: 16'h0000};

    int          total = 0;
    int          bad = 0;
    int          lat, nwr, rb;
    logic [3:0]  wa0, wa1;
    logic [15:0] wd0, wd1, r1, r2;
    logic        c;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    always @(posedge clk) if (rf_we === 1'b1) rf[rf_waddr] <= rf_wdata;

    reg_access_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_a_i(cmd_addr_a), .cmd_addr_b_i(cmd_addr_b), .cmd_addr_d_i(cmd_addr_d),
        .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data1_o(rsp_data1), .rsp_data2_o(rsp_data2), .rsp_carry_o(rsp_carry),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .rf_raddr1_o(rf_raddr1), .rf_raddr2_o(rf_raddr2),
        .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2)
    );

    // Runs one command end to end, logging writes, latency (edges from accept) and response.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, input logic [15:0] wd);
        @(negedge clk);
        cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_d = d; cmd_wdata = wd;
        cmd_valid = 1'b1;
        rb = (cmd_ready !== 1'b1) ? 1 : 0;
        nwr = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            if (cmd_ready !== 1'b0) rb++;
            if (rf_we === 1'b1) begin
                if (nwr == 0) begin wa0 = rf_waddr; wd0 = rf_wdata; end
                else if (nwr == 1) begin wa1 = rf_waddr; wd1 = rf_wdata; end
                nwr++;
            end else if (rf_waddr !== 4'h0 || rf_wdata !== 16'h0) begin
                rb++;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r1 = rsp_data1; r2 = rsp_data2; c = rsp_carry;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_addr_a = '0; cmd_addr_b = '0; cmd_addr_d = '0; cmd_wdata = '0;
        #2 rst_ni = 1'b0;
        #1;
        total++; if ({cmd_ready, rsp_valid, rf_we, rsp_carry} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {cmd_ready, rsp_valid, rf_we, rsp_carry}); end
        total++; if ({rf_waddr, rf_raddr1, rf_raddr2, rf_wdata, rsp_data1, rsp_data2} !== 60'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {rf_waddr, rf_raddr1, rf_raddr2, rf_wdata, rsp_data1, rsp_data2}); end
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write_read;
        run_cmd(OP_WR, 4'd6, 4'd0, 4'd0, 16'd25);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_lat got=%0d exp=3", lat); end
        total++; if (nwr !== 1 || wa0 !== 4'd6 || wd0 !== 16'd25) begin bad++; $display("FAIL wr_write got n=%0d a=%0d d=%0d exp n=1 a=6 d=25", nwr, wa0, wd0); end
        total++; if (rb !== 0) begin bad++; $display("FAIL wr_side got=%0d exp=0", rb); end
        run_cmd(OP_RD, 4'd6, 4'd0, 4'd0, 16'hFFFF);
        total++; if (nwr !== 0 || lat !== 3) begin bad++; $display("FAIL rd_nowrite got n=%0d lat=%0d exp n=0 lat=3", nwr, lat); end
        total++; if (r1 !== 16'd25 || r2 !== 16'd0 || c !== 1'b0) begin bad++; $display("FAIL rd_data got %h %h %b exp 0019 0000 0", r1, r2, c); end
    endtask

    task automatic test_add;
        run_cmd(OP_WR, 4'd3, 4'd0, 4'd0, 16'hFFFF);
        run_cmd(OP_WR, 4'd4, 4'd0, 4'd0, 16'h0002);
        run_cmd(OP_AD, 4'd3, 4'd4, 4'd5, 16'h0000);
        total++; if (lat !== 3) begin bad++; $display("FAIL add_lat got=%0d exp=3", lat); end
        total++; if (nwr !== 1 || wa0 !== 4'd5 || wd0 !== 16'h0001) begin bad++; $display("FAIL add_write got n=%0d a=%0d d=%h exp n=1 a=5 d=0001", nwr, wa0, wd0); end
        total++; if (r1 !== 16'hFFFF || r2 !== 16'h0002 || c !== 1'b1) begin bad++; $display("FAIL add_rsp got %h %h %b exp ffff 0002 1", r1, r2, c); end
        total++; if (rf[5] !== 16'h0001) begin bad++; $display("FAIL add_reg5 got=%h exp=0001", rf[5]); end
        // No-carry add into its own operand A.
        run_cmd(OP_WR, 4'd10, 4'd0, 4'd0, 16'h1234);
        run_cmd(OP_WR, 4'd11, 4'd0, 4'd0, 16'h0101);
        run_cmd(OP_AD, 4'd10, 4'd11, 4'd10, 16'h0000);
        total++; if (r1 !== 16'h1234 || r2 !== 16'h0101 || c !== 1'b0) begin bad++; $display("FAIL add_da_rsp got %h %h %b exp 1234 0101 0", r1, r2, c); end
        total++; if (wa0 !== 4'd10 || wd0 !== 16'h1335 || rb !== 0) begin bad++; $display("FAIL add_da_write got a=%0d d=%h side=%0d exp a=10 d=1335 side=0", wa0, wd0, rb); end
        run_cmd(OP_RD, 4'd10, 4'd11, 4'd0, 16'h0000);
        total++; if (r1 !== 16'h1335 || r2 !== 16'h0101) begin bad++; $display("FAIL add_da_read got %h %h exp 1335 0101", r1, r2); end
    endtask

    task automatic test_swap;
        run_cmd(OP_WR, 4'd1, 4'd0, 4'd0, 16'h00AA);
        run_cmd(OP_WR, 4'd2, 4'd0, 4'd0, 16'h0055);
        run_cmd(OP_SW, 4'd1, 4'd2, 4'd0, 16'h0000);
        total++; if (lat !== 4) begin bad++; $display("FAIL sw_lat got=%0d exp=4", lat); end
        total++; if (nwr !== 2 || wa0 !== 4'd1 || wd0 !== 16'h0055) begin bad++; $display("FAIL sw_first got n=%0d a=%0d d=%h exp n=2 a=1 d=0055", nwr, wa0, wd0); end
        total++; if (wa1 !== 4'd2 || wd1 !== 16'h00AA) begin bad++; $display("FAIL sw_second got a=%0d d=%h exp a=2 d=00aa", wa1, wd1); end
        total++; if (r1 !== 16'h00AA || r2 !== 16'h0055 || c !== 1'b0) begin bad++; $display("FAIL sw_rsp got %h %h %b exp 00aa 0055 0", r1, r2, c); end
        total++; if (rf[1] !== 16'h0055 || rf[2] !== 16'h00AA) begin bad++; $display("FAIL sw_regs got %h %h exp 0055 00aa", rf[1], rf[2]); end
        run_cmd(OP_WR, 4'd9, 4'd0, 4'd0, 16'h0BEE);
        run_cmd(OP_SW, 4'd9, 4'd9, 4'd0, 16'h0000);
        total++; if (nwr !== 2 || wd0 !== 16'h0BEE || wd1 !== 16'h0BEE || wa1 !== 4'd9) begin bad++; $display("FAIL sw_same got n=%0d %h %h a=%0d exp n=2 0bee 0bee a=9", nwr, wd0, wd1, wa1); end
        total++; if (rf[9] !== 16'h0BEE) begin bad++; $display("FAIL sw_same_reg got=%h exp=0bee", rf[9]); end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        cmd_op = OP_RD; cmd_addr_a = 4'd6; cmd_addr_b = 4'd0; cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Offer a conflicting WRITE and an early rsp_ready; both must be ignored.
        cmd_op = OP_WR; cmd_wdata = 16'hDEAD;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) rsp_ready = 1'b0;
        end
        rsp_ready = 1'b0;
        total++; if (n !== 2) begin bad++; $display("FAIL bp_lat got=%0d exp=2", n); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1 || rsp_data1 !== 16'd25 || rsp_data2 !== 16'd0 || cmd_ready !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got v=%b d1=%h d2=%h rdy=%b we=%b exp 1 0019 0000 0 0", i, rsp_valid, rsp_data1, rsp_data2, cmd_ready, rf_we); end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got rdy=%b v=%b exp 1 0", cmd_ready, rsp_valid); end
        total++; if (rf[6] !== 16'd25) begin bad++; $display("FAIL bp_ignored_cmd got=%h exp=0019", rf[6]); end
    endtask

    task automatic test_reset_wb2;
        run_cmd(OP_WR, 4'd7, 4'd0, 4'd0, 16'h1111);
        run_cmd(OP_WR, 4'd8, 4'd0, 4'd0, 16'h2222);
        @(negedge clk);
        cmd_op = OP_SW; cmd_addr_a = 4'd7; cmd_addr_b = 4'd8; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (rf_we !== 1'b1 || rf_waddr !== 4'd7 || rf_wdata !== 16'h2222) begin bad++; $display("FAIL rw_exec got we=%b a=%0d d=%h exp 1 7 2222", rf_we, rf_waddr, rf_wdata); end
        @(posedge clk);
        @(negedge clk);
        total++; if (rf_we !== 1'b1 || rf_waddr !== 4'd8 || rf_wdata !== 16'h1111) begin bad++; $display("FAIL rw_wb2 got we=%b a=%0d d=%h exp 1 8 1111", rf_we, rf_waddr, rf_wdata); end
        #2 rst_ni = 1'b0;
        #1;
        total++; if ({cmd_ready, rsp_valid, rf_we, rsp_carry, rf_waddr, rf_raddr1, rf_raddr2, rf_wdata, rsp_data1, rsp_data2} !== 64'h0) begin bad++; $display("FAIL rw_async_zero got we=%b a=%0d d=%h d1=%h", rf_we, rf_waddr, rf_wdata, rsp_data1); end
        @(posedge clk);
        @(negedge clk);
        total++; if (rf[7] !== 16'h2222 || rf[8] !== 16'h2222) begin bad++; $display("FAIL rw_regs got %h %h exp 2222 2222", rf[7], rf[8]); end
        rst_ni = 1'b1;
        run_cmd(OP_RD, 4'd7, 4'd8, 4'd0, 16'h0000);
        total++; if (rb !== 0 || lat !== 3) begin bad++; $display("FAIL rw_first_accept got side=%0d lat=%0d exp 0 3", rb, lat); end
        total++; if (r1 !== 16'h2222 || r2 !== 16'h2222) begin bad++; $display("FAIL rw_readback got %h %h exp 2222 2222", r1, r2); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_add;
        test_swap;
        test_backpressure;
        test_reset_wb2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
